key_decoder: RTL and testbench
==============================

# key_decoder

Converts PS/2 keyboard scan-code bytes (set 2) into held-key levels for character movement and a start pulse. It sits between the PS/2 byte receiver and the character controller, driving `stepleft`, `stepright` and `stepjump`, and the game-start input. It tracks make/break and extended-prefix sequences, suppresses typematic repeats, and recovers from truncated sequences with a timeout.

## Interface
- `TIMEOUT_CYCLES`, default 650_000: cycles allowed between a prefix byte (E0/F0) and the next byte before the FSM abandons the sequence. This is 10 ms at 65 MHz.
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `rx_data` input 8: scan-code byte from the PS/2 receiver.
- `rx_valid` input 1: one-cycle strobe. `rx_data` is valid when this is high.
- `stepleft` output 1: high while A (1C) or Left arrow (E0 6B) is held.
- `stepright` output 1: high while D (23) or Right arrow (E0 74) is held.
- `stepjump` output 1: high while W (1D), Space (29) or Up arrow (E0 75) is held.
- `game_start` output 1: one-cycle pulse on a fresh Enter (5A) make.

## Operation
- There are 8 internal held flags: A, D, W, SPACE, LEFT, RIGHT, UP, ENTER.
  - Each output is the OR of its alias flags, registered.
- FSM states: IDLE, EXT, BRK, EXT_BRK.
- Transitions are evaluated only when `rx_valid` = 1. Otherwise the state holds and the timeout counts.
- From IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - A known non-extended code sets its flag and stays in IDLE.
  - Any other byte is ignored and stays in IDLE.
- From EXT:
  - F0 → EXT_BRK.
  - E0 → EXT (the counter restarts).
  - 6B, 74 or 75 sets LEFT, RIGHT or UP respectively → IDLE.
  - Any other byte → IDLE, no flag change.
- From BRK:
  - A known non-extended code clears its flag → IDLE.
  - Any other byte → IDLE.
- From EXT_BRK:
  - 6B, 74 or 75 clears its flag → IDLE.
  - Any other byte → IDLE.
- Extended codes never touch non-extended flags, and vice versa. Example: E0 1C does not set A.
- Typematic repeats: a make for a flag already set leaves the flag set and produces no `game_start` pulse.
- `game_start` fires only when the Enter make arrives while ENTER = 0. It is cleared on the next cycle.
- Timeout: a counter of width ≥ ceil(log2(`TIMEOUT_CYCLES`+1)) runs in EXT, BRK and EXT_BRK.
  - It resets to 0 on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES`-1 with no byte arriving, the FSM returns to IDLE.
  - Flags are unchanged by a timeout.
- The counter is held at 0 in IDLE.
- Opposite directions held together (A and D) drive both `stepleft` and `stepright` high. Arbitration belongs downstream.
- Releasing one alias while the other is still held keeps the output high. Example: A released while LEFT is held leaves `stepleft` = 1.

## Timing
- Reset values:
  - `stepleft`, `stepright`, `stepjump`, `game_start` = 0.
  - All flags = 0.
  - FSM = IDLE, counter = 0.
- Reset applied mid-sequence discards the partial sequence. The byte after reset is decoded from IDLE.
- Latency: a byte completing a make or break on cycle N (with `rx_valid` = 1) changes the level outputs on cycle N+1.
- `game_start` is high exactly during cycle N+1.
- Prefix bytes (E0, F0) never change any output.
- Back-to-back `rx_valid` on consecutive cycles is supported: one byte is consumed per cycle with no stall.
- Timeout boundary: with a prefix accepted at cycle N and no further byte, the FSM is in IDLE at cycle N+`TIMEOUT_CYCLES`.
  - A byte arriving at cycle N+`TIMEOUT_CYCLES`-1 is still decoded in the prefixed state.

## Test plan
- Send 1C, then F0 1C 20 cycles later → `stepleft` rises at cycle+1 after 1C and falls at cycle+1 after the 1C following F0. Other outputs stay 0.
- Send 1C, then E0 6B, then F0 1C → `stepleft` stays 1 throughout. Then E0 F0 6B → `stepleft` = 0.
- Send 5A three times (typematic), then F0 5A, then 5A → `game_start` pulses exactly twice, each one cycle wide.
- Send E0 and wait `TIMEOUT_CYCLES` cycles, then 6B (no prefix) → the FSM has returned to IDLE and 6B is ignored, `stepleft` = 0. Repeat with 6B sent at `TIMEOUT_CYCLES`-2 cycles → `stepleft` = 1.
- Hold 23 and 1D, assert `rst` for 1 cycle between F0 and 23 → all outputs are 0 after reset. The following 23 is a make, so `stepright` = 1.
- Send back-to-back bytes on consecutive cycles: 29, E0, 74, F0, 29 → `stepjump` is 1 for 4 cycles, then 0. `stepright` = 1 from the cycle after 74.

Source files
------------

// File: rtl/key_decoder.sv
// key_decoder: turns PS/2 set-2 scan-code bytes into held-key movement levels
// (stepleft / stepright / stepjump) and a one-cycle game_start pulse.
// Tracks make / break / E0-extended sequences, swallows typematic repeats and
// abandons a dangling prefix after TIMEOUT_CYCLES idle cycles.
module key_decoder #(
    parameter int TIMEOUT_CYCLES = 650_000   // must be >= 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       stepleft,
    output logic       stepright,
    output logic       stepjump,
    output logic       game_start
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // The FSM leaves a prefixed state on the edge where the count would reach
    // TIMEOUT_CYCLES-1, so the last byte still decoded in that state is the
    // one at prefix + TIMEOUT_CYCLES - 1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    // Held-flag bit positions
    localparam int F_A     = 0;
    localparam int F_D     = 1;
    localparam int F_W     = 2;
    localparam int F_SPACE = 3;
    localparam int F_LEFT  = 4;
    localparam int F_RIGHT = 5;
    localparam int F_UP    = 6;
    localparam int F_ENTER = 7;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       flags_p1;

    logic [7:0]       set_mask_p0;
    logic [7:0]       clr_mask_p0;
    logic [7:0]       flags_nxt_p0;
    logic             vld_p0;

    // Flag mask for a non-extended code; unknown codes give no flag.
    function automatic logic [7:0] base_mask(input logic [7:0] code);
        logic [7:0] m;
        m = 8'h00;
        case (code)
            8'h1C:   m[F_A]     = 1'b1;
            8'h23:   m[F_D]     = 1'b1;
            8'h1D:   m[F_W]     = 1'b1;
            8'h29:   m[F_SPACE] = 1'b1;
            8'h5A:   m[F_ENTER] = 1'b1;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    // Flag mask for the code following an E0 prefix.
    function automatic logic [7:0] ext_mask(input logic [7:0] code);
        logic [7:0] m;
        m = 8'h00;
        case (code)
            8'h6B:   m[F_LEFT]  = 1'b1;
            8'h74:   m[F_RIGHT] = 1'b1;
            8'h75:   m[F_UP]    = 1'b1;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    assign vld_p0 = rx_valid;

    // Decode stage: which flags this byte sets or clears in the current state.
    // Prefix bytes map to no flag in every table, so they never touch outputs.
    always_comb begin
        set_mask_p0 = 8'h00;
        clr_mask_p0 = 8'h00;
        if (vld_p0) begin
            case (state)
                IDLE:    set_mask_p0 = base_mask(rx_data);
                EXT:     set_mask_p0 = ext_mask(rx_data);
                BRK:     clr_mask_p0 = base_mask(rx_data);
                EXT_BRK: clr_mask_p0 = ext_mask(rx_data);
                default: begin
                    set_mask_p0 = 8'h00;
                    clr_mask_p0 = 8'h00;
                end
            endcase
        end
    end

    assign flags_nxt_p0 = (flags_p1 | set_mask_p0) & ~clr_mask_p0;

    // Register stage: sequence FSM, prefix timeout, held flags and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            flags_p1   <= 8'h00;
            stepleft   <= 1'b0;
            stepright  <= 1'b0;
            stepjump   <= 1'b0;
            game_start <= 1'b0;
        end else begin
            flags_p1   <= flags_nxt_p0;
            stepleft   <= flags_nxt_p0[F_A] | flags_nxt_p0[F_LEFT];
            stepright  <= flags_nxt_p0[F_D] | flags_nxt_p0[F_RIGHT];
            stepjump   <= flags_nxt_p0[F_W] | flags_nxt_p0[F_SPACE] | flags_nxt_p0[F_UP];
            // Only a fresh Enter make fires; a typematic repeat finds ENTER set.
            game_start <= set_mask_p0[F_ENTER] & ~flags_p1[F_ENTER];

            if (vld_p0) begin
                cnt <= '0;
                case (state)
                    IDLE: begin
                        if (rx_data == CODE_EXT)
                            state <= EXT;
                        else if (rx_data == CODE_BRK)
                            state <= BRK;
                        else
                            state <= IDLE;
                    end
                    EXT: begin
                        if (rx_data == CODE_BRK)
                            state <= EXT_BRK;
                        else if (rx_data == CODE_EXT)
                            state <= EXT;
                        else
                            state <= IDLE;
                    end
                    BRK:     state <= IDLE;
                    EXT_BRK: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Truncated sequence: drop the prefix, keep the flags.
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_key_decoder.sv
// Directed testbench for key_decoder with a short prefix timeout.
module tb_key_decoder;

    localparam int T = 16;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       stepleft;
    logic       stepright;
    logic       stepjump;
    logic       game_start;
    logic [3:0] outs;

    int checks;
    int errors;
    int gs_cnt;

    key_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .stepleft   (stepleft),
        .stepright  (stepright),
        .stepjump   (stepjump),
        .game_start (game_start)
    );

    assign outs = {stepleft, stepright, stepjump, game_start};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count game_start pulses, sampled on the falling edge
    always @(negedge clk) begin
        if (game_start) gs_cnt <= gs_cnt + 1;
    end

    // Drive one byte from a falling edge; it is consumed at the next rising
    // edge and the task returns at the following falling edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [3:0] exp);
        checks++;
        if (outs !== exp) begin
            errors++;
            $display("FAIL %s: outs(L,R,J,S) got %b want %b", name, outs, exp);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        idle(3);
        chk("reset_outputs", 4'b0000);
        rst = 1'b0;
        idle(1);
        chk("after_reset_release", 4'b0000);
    endtask

    task automatic test_make_break;
        send(8'h1C);  chk("a_make", 4'b1000);
        idle(20);     chk("a_held", 4'b1000);
        send(8'hF0);  chk("a_brk_prefix", 4'b1000);
        send(8'h1C);  chk("a_break", 4'b0000);
        send(8'h55);  chk("unknown_ignored", 4'b0000);
        send(8'hE0);
        send(8'h1C);  chk("ext_1c_not_a", 4'b0000);
    endtask

    task automatic test_alias;
        send(8'h1C);  chk("alias_a", 4'b1000);
        send(8'hE0);  chk("alias_e0", 4'b1000);
        send(8'h6B);  chk("alias_left", 4'b1000);
        send(8'hF0);
        send(8'h1C);  chk("alias_a_rel_left_held", 4'b1000);
        send(8'hE0);
        send(8'hF0);  chk("alias_prefixes", 4'b1000);
        send(8'h6B);  chk("alias_left_rel", 4'b0000);
        send(8'h1C);
        send(8'h23);  chk("opposite_both", 4'b1100);
        send(8'hF0);
        send(8'h1C);  chk("opposite_a_rel", 4'b0100);
        send(8'hF0);
        send(8'h23);  chk("opposite_d_rel", 4'b0000);
    endtask

    task automatic test_typematic;
        gs_cnt = 0;
        send(8'h5A);  chk("enter_make_pulse", 4'b0001);
        idle(1);      chk("enter_pulse_end", 4'b0000);
        send(8'h5A);  chk("enter_repeat1", 4'b0000);
        send(8'h5A);  chk("enter_repeat2", 4'b0000);
        send(8'hF0);
        send(8'h5A);  chk("enter_break", 4'b0000);
        send(8'h5A);  chk("enter_remake_pulse", 4'b0001);
        idle(2);      chk("enter_remake_end", 4'b0000);
        checks++;
        if (gs_cnt !== 2) begin
            errors++;
            $display("FAIL gs_pulse_count: got %0d want 2", gs_cnt);
        end
        send(8'hF0);
        send(8'h5A);
    endtask

    task automatic test_timeout;
        send(8'hE0);  idle(T - 1);
        send(8'h6B);  chk("timeout_expired_ignored", 4'b0000);
        send(8'hE0);  idle(T - 2);
        send(8'h6B);  chk("timeout_last_cycle_decoded", 4'b1000);
        send(8'hE0);
        send(8'hF0);
        send(8'h6B);  chk("timeout_left_rel", 4'b0000);
        send(8'hE0);  idle(T - 3);
        send(8'h6B);  chk("timeout_early_decoded", 4'b1000);
        send(8'hE0);
        send(8'hF0);
        send(8'h6B);  chk("timeout_left_rel2", 4'b0000);
        send(8'h1C);
        send(8'hF0);  idle(T + 2);
        chk("timeout_keeps_flags", 4'b1000);
        send(8'h1C);  chk("timeout_brk_dropped", 4'b1000);
        send(8'hF0);
        send(8'h1C);  chk("timeout_cleanup", 4'b0000);
    endtask

    task automatic test_reset_mid;
        send(8'h23);  chk("rm_d", 4'b0100);
        send(8'h1D);  chk("rm_w", 4'b0110);
        send(8'hF0);  chk("rm_prefix", 4'b0110);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rm_after_reset", 4'b0000);
        send(8'h23);  chk("rm_d_make_after_reset", 4'b0100);
        send(8'hF0);
        send(8'h23);  chk("rm_cleanup", 4'b0000);
    endtask

    task automatic test_back_to_back;
        send(8'h29);  chk("b2b_space", 4'b0010);
        send(8'hE0);  chk("b2b_e0", 4'b0010);
        send(8'h74);  chk("b2b_right", 4'b0110);
        send(8'hF0);  chk("b2b_f0", 4'b0110);
        send(8'h29);  chk("b2b_space_rel", 4'b0100);
        idle(1);      chk("b2b_hold", 4'b0100);
        send(8'hE0);
        send(8'hF0);
        send(8'h74);  chk("b2b_cleanup", 4'b0000);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        gs_cnt = 0;
        test_reset();
        test_make_break();
        test_alias();
        test_typematic();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
